wb_grf: RTL and testbench
=========================

# wb_grf

Write-back stage and general register file for the five-stage pipelined MIPS core. It consumes the W-stage values latched by the MEM/WB pipeline register and decodes `W_Instr` to pick the write-back source and destination. Load data is byte/half aligned and extended, and the result is committed into a 32×32 register file that the decode stage reads. It also exports the W-stage write for the hazard/forwarding unit and keeps a retired-instruction counter.

## Interface

- No parameters.
- `clk` input 1: core clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; low clears all state immediately.
- `W_Instr` input 32: W-stage instruction; 0 is a bubble (nop).
- `W_C` input 32: ALU result, also load address (low 2 bits used as byte offset).
- `W_DR` input 32: raw aligned memory word read for loads.
- `W_PC` input 32: W-stage PC, trace only.
- `W_PC8` input 32: PC+8 for link instructions.
- `A1`, `A2` input 5 each: decode-stage read addresses.
- `RD1`, `RD2` output 32 each: read data, combinational.
- `W_A3` output 5: effective destination; 0 when no write.
- `W_WD` output 32: write-back data after source selection and load extension.
- `W_WE` output 1: register write strobe; 1 only if the instruction writes and `W_A3` is nonzero.
- `trace_valid` output 1: equals `W_WE`.
- `trace_pc` output 32: equals `W_PC`.
- `retire_cnt` output 32: count of non-bubble instructions that passed W.

## Operation

- Decode is on `W_Instr[31:26]` (op) and `[5:0]` (funct):
  - op 0, funct 0x21/0x23/0x2a/0x00 (addu/subu/slt/sll): A3=rd, data=`W_C`.
  - op 0, funct 0x09 (jalr): A3=rd, data=`W_PC8`.
  - op 0, funct 0x08 (jr): no write.
  - op 0x09/0x0d/0x0f (addiu/ori/lui): A3=rt, data=`W_C`.
  - op 0x03 (jal): A3=31, data=`W_PC8`.
  - op 0x23 (lw): A3=rt, data=`W_DR`.
  - op 0x20/0x24 (lb/lbu): A3=rt, data = byte `W_DR[8*W_C[1:0]+:8]`, sign- or zero-extended.
  - op 0x21/0x25 (lh/lhu): A3=rt, data = half `W_DR[16*W_C[1]+:16]`, sign- or zero-extended; `W_C[0]` ignored.
  - Any other op (stores, branches, unknown): no write, `W_A3`=0.
- Register file: 32 entries. Entry 0 is never written and always reads 0.
- Write: on a rising edge with `W_WE`=1, `reg[W_A3]` <= `W_WD`.
- Read: `RD1`=`reg[A1]` and `RD2`=`reg[A2]`, subject to the bypass described under Configuration.
- Counter: `retire_cnt` increments by 1 each rising edge when `W_Instr` != 0, including non-writing instructions. It wraps from 0xFFFFFFFF to 0.

## Timing

- Decode, extension, `W_A3`/`W_WD`/`W_WE`, and `RD1`/`RD2` are purely combinational, with zero-cycle latency.
- A register write becomes visible through the array one edge after `W_WE`.
- Reset: while `reset`=0, all 32 entries and `retire_cnt` are 0 asynchronously. Outputs read 0 regardless of address. Writes and counting are suppressed during that time.
- Reset deassertion mid-stream: the first rising edge with `reset`=1 performs a normal write/count.
- If `A1`==`A2`, both ports return identical data.
- A write to register 0 is dropped: `W_WE`=0 and `retire_cnt` still counts it.

## Configuration

- `GRF_BYPASS_EN` defined:
  - Internal write-through is enabled.
  - If `W_WE`=1 and `A1`==`W_A3`, then `RD1`=`W_WD`. The same applies to `A2`/`RD2`.
  - Same-cycle write-then-read returns the new value.
- `GRF_BYPASS_EN` undefined:
  - `RD1`/`RD2` come from the array only.
  - A same-cycle read returns the old value; the hazard unit must forward from `W_WD`.

## Test plan

- **Reset:** drive `reset`=0 mid-run after writing $5=0x1234. Required: `RD1`(A1=5)=0 and `retire_cnt`=0 immediately, without waiting for a clock.
- **ori:** `W_Instr`=0x34A5FFFF (ori $5,$5,0xFFFF), `W_C`=0x0000FFFF. Required: `W_A3`=5 and `W_WE`=1. Next cycle `RD1`(A1=5)=0x0000FFFF. In the write cycle `RD1` is 0x0000FFFF with `GRF_BYPASS_EN` defined and 0 without it.
- **Load extension:** lb with `W_DR`=0x80FF7F01, `W_C`[1:0]=3. Required: `W_WD`=0xFFFFFF80. Then lbu with offset 2 gives 0x000000FF, and lh with `W_C`[1]=1 gives 0xFFFF80FF.
- **jal:** jal with `W_PC8`=0x00003010. Required: `W_A3`=31 and `W_WD`=0x00003010. `reg[31]` holds that value next cycle.
- **No-write cases:** apply bubble 0x00000000, then sw (op 0x2b), then addu to $0. Required: `W_WE`=0 for all three. `retire_cnt` advances by 2 (sw and addu); `RD1`(A1=0)=0 throughout.
- **Counter wrap:** force 2^32−1 non-bubble retires, or preload in the bench. Required: the next retire gives `retire_cnt`=0.

Source files
------------

// File: rtl/wb_grf_if.sv
// wb_grf_if: W-stage bundle between the MEM/WB pipeline register, the
// decode-stage read ports, the hazard unit and the write-back/register-file
// block. The pipeline side uses the master modport and wb_grf uses the slave.
interface wb_grf_if;
  logic [31:0] W_Instr;
  logic [31:0] W_C;
  logic [31:0] W_DR;
  logic [31:0] W_PC;
  logic [31:0] W_PC8;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [4:0]  W_A3;
  logic [31:0] W_WD;
  logic        W_WE;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] retire_cnt;

  modport master (
    output W_Instr, W_C, W_DR, W_PC, W_PC8, A1, A2,
    input  RD1, RD2, W_A3, W_WD, W_WE, trace_valid, trace_pc, retire_cnt
  );

  modport slave (
    input  W_Instr, W_C, W_DR, W_PC, W_PC8, A1, A2,
    output RD1, RD2, W_A3, W_WD, W_WE, trace_valid, trace_pc, retire_cnt
  );
endinterface

// File: rtl/wb_grf.sv
// wb_grf: write-back stage and 32x32 general register file of the five-stage
// MIPS core. Decodes W_Instr to select the write-back source and destination,
// aligns and extends load data, commits into the register file and counts
// retired (non-bubble) instructions.
// Optional feature: define GRF_BYPASS_EN to enable write-through from the
// W-stage write to the read ports in the same cycle.
// reset is asynchronous and active-low.
module wb_grf (
  input logic   clk,
  input logic   reset,
  wb_grf_if.slave bus
);

  typedef enum logic [2:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_PC8,
    SRC_WORD,
    SRC_BYTE,
    SRC_HALF
  } src_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_SLT     = 6'h2a;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  src_e        src;
  logic        load_signed;
  logic [4:0]  dest;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [31:0] regs [32];
  logic [31:0] retire_cnt_q;
  logic [31:0] rd1_data;
  logic [31:0] rd2_data;
  logic        unused_instr_bits;

  assign op    = bus.W_Instr[31:26];
  assign funct = bus.W_Instr[5:0];
  assign rt    = bus.W_Instr[20:16];
  assign rd    = bus.W_Instr[15:11];

  // rs and shamt never matter at write-back
  assign unused_instr_bits = ^{bus.W_Instr[25:21], bus.W_Instr[10:6]};

  // Instruction decode: choose the write-back source and destination register
  always_comb begin
    src         = SRC_NONE;
    dest        = 5'd0;
    load_signed = 1'b0;
    unique case (op)
      OP_SPECIAL: begin
        case (funct)
          FN_ADDU, FN_SUBU, FN_SLT, FN_SLL: begin
            src  = SRC_ALU;
            dest = rd;
          end
          FN_JALR: begin
            src  = SRC_PC8;
            dest = rd;
          end
          default: ;
        endcase
      end
      OP_ADDIU, OP_ORI, OP_LUI: begin
        src  = SRC_ALU;
        dest = rt;
      end
      OP_JAL: begin
        src  = SRC_PC8;
        dest = 5'd31;
      end
      OP_LW: begin
        src  = SRC_WORD;
        dest = rt;
      end
      OP_LB, OP_LBU: begin
        src         = SRC_BYTE;
        dest        = rt;
        load_signed = (op == OP_LB);
      end
      OP_LH, OP_LHU: begin
        src         = SRC_HALF;
        dest        = rt;
        load_signed = (op == OP_LH);
      end
      default: ;
    endcase
  end

  // Byte lane picked by the full offset; halfword lane only by bit 1
  assign load_byte = bus.W_DR[{bus.W_C[1:0], 3'b000} +: 8];
  assign load_half = bus.W_DR[{bus.W_C[1], 4'b0000} +: 16];

  // Write-back data mux with load sign/zero extension
  always_comb begin
    wb_data = 32'd0;
    case (src)
      SRC_ALU:  wb_data = bus.W_C;
      SRC_PC8:  wb_data = bus.W_PC8;
      SRC_WORD: wb_data = bus.W_DR;
      SRC_BYTE: wb_data = {{24{load_signed & load_byte[7]}}, load_byte};
      SRC_HALF: wb_data = {{16{load_signed & load_half[15]}}, load_half};
      default:  wb_data = 32'd0;
    endcase
  end

  // A write to $0 is dropped entirely, so the strobe only fires for $1..$31
  assign wb_en = (dest != 5'd0);

  assign bus.W_A3        = dest;
  assign bus.W_WD        = wb_data;
  assign bus.W_WE        = wb_en;
  assign bus.trace_valid = wb_en;
  assign bus.trace_pc    = bus.W_PC;

  // Register array: cleared by reset, one write per cycle, $0 never written
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (wb_en) begin
      regs[dest] <= wb_data;
    end
  end

  // Retired-instruction counter: every non-bubble instruction, wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt_q <= 32'd0;
    end else if (bus.W_Instr != 32'd0) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign bus.retire_cnt = retire_cnt_q;

  // Read ports; with write-through the pending W-stage write wins over the array
  always_comb begin
    rd1_data = regs[bus.A1];
    rd2_data = regs[bus.A2];
`ifdef GRF_BYPASS_EN
    if (reset && wb_en && (bus.A1 == dest)) begin
      rd1_data = wb_data;
    end
    if (reset && wb_en && (bus.A2 == dest)) begin
      rd2_data = wb_data;
    end
`else
    // Same-cycle reads see the old array value; the hazard unit forwards W_WD
`endif
  end

  assign bus.RD1 = rd1_data;
  assign bus.RD2 = rd2_data;

endmodule

// File: tb/tb_wb_grf.sv
// tb_wb_grf: directed self-checking bench for wb_grf. A table of decode
// vectors covers every write-back source and load extension case; hand
// sequences cover reset, register commit, no-write cases and counter wrap.
module tb_wb_grf;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_cnt;
  logic [31:0] cnt_base;

  wb_grf_if bus ();

  wb_grf dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef GRF_BYPASS_EN
  localparam logic [31:0] ORI_SAME_CYCLE = 32'h0000FFFF;
`else
  localparam logic [31:0] ORI_SAME_CYCLE = 32'h00000000;
`endif

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] c;
    logic [31:0] dr;
    logic [31:0] pc8;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        we;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  // Free-running core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference retire counter
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_cnt = 32'd0;
    else if (bus.W_Instr != 32'd0) exp_cnt = exp_cnt + 32'd1;
  end

  // Hard stop in case anything stalls
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] instr, input logic [31:0] c,
                                input logic [31:0] dr, input logic [31:0] pc8);
    bus.W_Instr = instr;
    bus.W_C     = c;
    bus.W_DR    = dr;
    bus.W_PC8   = pc8;
    bus.W_PC    = pc8 - 32'd8;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    vecs[0]  = '{"ori",      32'h34A5FFFF, 32'h0000FFFF, 32'h80FF7F01, 32'h00003010, 5'd5,  32'h0000FFFF, 1'b1};
    vecs[1]  = '{"addu",     32'h00221821, 32'h12345678, 32'h80FF7F01, 32'h00003010, 5'd3,  32'h12345678, 1'b1};
    vecs[2]  = '{"subu",     32'h00221823, 32'hFFFFFFFE, 32'h80FF7F01, 32'h00003010, 5'd3,  32'hFFFFFFFE, 1'b1};
    vecs[3]  = '{"slt",      32'h0022182A, 32'h00000001, 32'h80FF7F01, 32'h00003010, 5'd3,  32'h00000001, 1'b1};
    vecs[4]  = '{"sll",      32'h000220C0, 32'h00000040, 32'h80FF7F01, 32'h00003010, 5'd4,  32'h00000040, 1'b1};
    vecs[5]  = '{"addiu",    32'h24260010, 32'h00000010, 32'h80FF7F01, 32'h00003010, 5'd6,  32'h00000010, 1'b1};
    vecs[6]  = '{"lui",      32'h3C071234, 32'h12340000, 32'h80FF7F01, 32'h00003010, 5'd7,  32'h12340000, 1'b1};
    vecs[7]  = '{"jalr",     32'h0120F809, 32'h00000000, 32'h80FF7F01, 32'h00003010, 5'd31, 32'h00003010, 1'b1};
    vecs[8]  = '{"jr",       32'h01200008, 32'h00000000, 32'h80FF7F01, 32'h00003010, 5'd0,  32'h00000000, 1'b0};
    vecs[9]  = '{"lw",       32'h8D280000, 32'h00001000, 32'h80FF7F01, 32'h00003010, 5'd8,  32'h80FF7F01, 1'b1};
    vecs[10] = '{"lb_off3",  32'h81280000, 32'h00001003, 32'h80FF7F01, 32'h00003010, 5'd8,  32'hFFFFFF80, 1'b1};
    vecs[11] = '{"lb_off1",  32'h81280000, 32'h00001001, 32'h80FF7F01, 32'h00003010, 5'd8,  32'h0000007F, 1'b1};
    vecs[12] = '{"lb_off0",  32'h81280000, 32'h00001000, 32'h80FF7F01, 32'h00003010, 5'd8,  32'h00000001, 1'b1};
    vecs[13] = '{"lbu_off2", 32'h91280000, 32'h00001002, 32'h80FF7F01, 32'h00003010, 5'd8,  32'h000000FF, 1'b1};
    vecs[14] = '{"lbu_off3", 32'h91280000, 32'h00001003, 32'h80FF7F01, 32'h00003010, 5'd8,  32'h00000080, 1'b1};
    vecs[15] = '{"lh_off2",  32'h85280000, 32'h00001002, 32'h80FF7F01, 32'h00003010, 5'd8,  32'hFFFF80FF, 1'b1};
    vecs[16] = '{"lh_off3",  32'h85280000, 32'h00001003, 32'h80FF7F01, 32'h00003010, 5'd8,  32'hFFFF80FF, 1'b1};
    vecs[17] = '{"lhu_off0", 32'h95280000, 32'h00001000, 32'h80FF7F01, 32'h00003010, 5'd8,  32'h00007F01, 1'b1};
    vecs[18] = '{"lhu_off2", 32'h95280000, 32'h00001002, 32'h80FF7F01, 32'h00003010, 5'd8,  32'h000080FF, 1'b1};
    vecs[19] = '{"sw",       32'hAD280000, 32'h00001000, 32'h80FF7F01, 32'h00003010, 5'd0,  32'h00000000, 1'b0};
    vecs[20] = '{"beq",      32'h10220003, 32'h00000000, 32'h80FF7F01, 32'h00003010, 5'd0,  32'h00000000, 1'b0};
    vecs[21] = '{"bubble",   32'h00000000, 32'h00000000, 32'h80FF7F01, 32'h00003010, 5'd0,  32'h00000000, 1'b0};
    vecs[22] = '{"addu_r0",  32'h00220021, 32'h0000DEAD, 32'h80FF7F01, 32'h00003010, 5'd0,  32'h00000000, 1'b0};
    vecs[23] = '{"jal",      32'h0C000C04, 32'h00000000, 32'h80FF7F01, 32'h00005010, 5'd31, 32'h00005010, 1'b1};

    // Reset held from time zero
    reset  = 1'b0;
    bus.A1 = 5'd5;
    bus.A2 = 5'd31;
    apply_stimulus(32'h0, 32'h0, 32'h0, 32'h8);
    #3;
    check_output("rst_rd1",  bus.RD1, 32'h0);
    check_output("rst_rd2",  bus.RD2, 32'h0);
    check_output("rst_cnt",  bus.retire_cnt, 32'h0);
    check_output("rst_we",   {31'd0, bus.W_WE}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // ori $5: write-cycle read depends on write-through, next cycle sees new value
    @(negedge clk);
    bus.A1 = 5'd5;
    bus.A2 = 5'd5;
    apply_stimulus(32'h34A5FFFF, 32'h0000FFFF, 32'h0, 32'h00001008);
    #1;
    check_output("ori_a3",      {27'd0, bus.W_A3}, 32'd5);
    check_output("ori_we",      {31'd0, bus.W_WE}, 32'd1);
    check_output("ori_trace",   {31'd0, bus.trace_valid}, 32'd1);
    check_output("ori_tpc",     bus.trace_pc, 32'h00001000);
    check_output("ori_rd1_now", bus.RD1, ORI_SAME_CYCLE);
    check_output("ori_rd2_now", bus.RD2, ORI_SAME_CYCLE);
    @(negedge clk);
    apply_stimulus(32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check_output("ori_rd1_next", bus.RD1, 32'h0000FFFF);
    check_output("ori_rd2_next", bus.RD2, 32'h0000FFFF);

    // jal commits PC+8 into $31
    @(negedge clk);
    bus.A1 = 5'd31;
    apply_stimulus(32'h0C000C04, 32'h0, 32'h0, 32'h00003010);
    #1;
    check_output("jal_a3", {27'd0, bus.W_A3}, 32'd31);
    check_output("jal_wd", bus.W_WD, 32'h00003010);
    @(negedge clk);
    apply_stimulus(32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check_output("jal_reg31", bus.RD1, 32'h00003010);
    check_output("cnt_after_jal", bus.retire_cnt, exp_cnt);

    // Decode table
    bus.A1 = 5'd0;
    bus.A2 = 5'd0;
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i].instr, vecs[i].c, vecs[i].dr, vecs[i].pc8);
      #1;
      check_output({vecs[i].name, "_a3"}, {27'd0, bus.W_A3}, {27'd0, vecs[i].a3});
      check_output({vecs[i].name, "_we"}, {31'd0, bus.W_WE}, {31'd0, vecs[i].we});
      check_output({vecs[i].name, "_tv"}, {31'd0, bus.trace_valid}, {31'd0, vecs[i].we});
      if (vecs[i].we) check_output({vecs[i].name, "_wd"}, bus.W_WD, vecs[i].wd);
    end
    @(negedge clk);
    apply_stimulus(32'h0, 32'h0, 32'h0, 32'h0);
    bus.A1 = 5'd8;
    bus.A2 = 5'd8;
    #1;
    check_output("tbl_reg8_p1", bus.RD1, 32'h000080FF);
    check_output("tbl_reg8_p2", bus.RD2, 32'h000080FF);
    check_output("tbl_cnt",     bus.retire_cnt, exp_cnt);

    // No-write cases: bubble, sw, addu to $0; only the last two count
    cnt_base = exp_cnt;
    bus.A1 = 5'd0;
    @(negedge clk);
    apply_stimulus(32'h00000000, 32'h0, 32'h0, 32'h0);
    #1;
    check_output("nw_bub_we", {31'd0, bus.W_WE}, 32'd0);
    check_output("nw_bub_r0", bus.RD1, 32'd0);
    @(negedge clk);
    apply_stimulus(32'hAD280000, 32'h00001000, 32'h0, 32'h0);
    #1;
    check_output("nw_sw_we", {31'd0, bus.W_WE}, 32'd0);
    check_output("nw_sw_r0", bus.RD1, 32'd0);
    @(negedge clk);
    apply_stimulus(32'h00220021, 32'h0000DEAD, 32'h0, 32'h0);
    #1;
    check_output("nw_addu0_we", {31'd0, bus.W_WE}, 32'd0);
    check_output("nw_addu0_r0", bus.RD1, 32'd0);
    @(negedge clk);
    apply_stimulus(32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check_output("nw_cnt_plus2", bus.retire_cnt, cnt_base + 32'd2);
    check_output("nw_r0_after",  bus.RD1, 32'd0);

    // Mid-run asynchronous reset after $5 = 0x1234
    @(negedge clk);
    bus.A1 = 5'd5;
    bus.A2 = 5'd31;
    apply_stimulus(32'h34051234, 32'h00001234, 32'h0, 32'h0);
    @(negedge clk);
    apply_stimulus(32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check_output("pre_rst_r5", bus.RD1, 32'h00001234);
    #1;
    reset = 1'b0;
    #1;
    check_output("async_rst_r5",  bus.RD1, 32'h0);
    check_output("async_rst_r31", bus.RD2, 32'h0);
    check_output("async_rst_cnt", bus.retire_cnt, 32'h0);

    // Writes suppressed while reset is held, first edge after release is live
    @(negedge clk);
    bus.A1 = 5'd6;
    apply_stimulus(32'h24060055, 32'h00000055, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    check_output("held_rst_r6",  bus.RD1, 32'h0);
    check_output("held_rst_cnt", bus.retire_cnt, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    apply_stimulus(32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check_output("post_rst_r6",  bus.RD1, 32'h00000055);
    check_output("post_rst_cnt", bus.retire_cnt, 32'd1);

    // Counter wrap from the all-ones value
    @(negedge clk);
    force dut.retire_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    check_output("wrap_preload", bus.retire_cnt, 32'hFFFFFFFF);
    apply_stimulus(32'hAD280000, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    apply_stimulus(32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check_output("wrap_zero", bus.retire_cnt, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
